// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage register for the RV32I pipeline.
// A valid/ready handshake carries a control field and a data field.
// The stage supports hold, flush and bubble insertion.
// With SKID=1 a second entry lets in_ready be a registered signal.
// With SKID=0 there is one entry and in_ready is combinational.
// occupancy and a saturating hold counter are exposed for hazard and performance debug.
module pipe_elastic_stage #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  hold_cnt
);

  // The state encoding is the number of beats held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              load_head_in;
  logic              load_head_skid;
  logic              load_skid;
  logic              in_fire;
  logic              out_fire;

  // Saturating increment: the counter stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign out_valid = (state != EMPTY);
  assign out_fire  = out_valid & out_ready & ~hold;
  assign in_fire   = in_valid & in_ready;
  // A bubble presents all-zero control, so downstream sees a NOP.
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  // Data is not zeroed on a bubble. It keeps the last head value.
  assign out_data  = head_data;
  assign occupancy = state;

  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;

      // Registered ready: accept next cycle unless the stage will then be full.
      always_ff @(posedge clk) begin
        if (!rst_n) ready_q <= 1'b1;
        else        ready_q <= (state_next != TWO);
      end

      assign in_ready = ready_q;
    end else begin : g_noskid
      // Single entry: accept when empty or when the head leaves this cycle.
      assign in_ready = ~out_valid | out_fire;
    end
  endgenerate

  // Next-state and entry-load decode. Flush overrides normal operation.
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next   = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_head_in = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_next     = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Head entry: loads from upstream or is promoted from the skid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ctrl <= '0;
      head_data <= '0;
    end else if (load_head_in) begin
      head_ctrl <= in_ctrl;
      head_data <= in_data;
    end else if (load_head_skid) begin
      head_ctrl <= skid_ctrl;
      head_data <= skid_data;
    end
  end

  // Skid entry: catches the beat accepted while the head is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // Count cycles where a valid head is held back. Only reset clears the count.
  always_ff @(posedge clk) begin
    if (!rst_n)                      hold_cnt <= '0;
    else if (out_valid && !out_fire) hold_cnt <= sat_inc(hold_cnt);
  end

endmodule
